// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman bit packer: FSM state encoding and
// width helpers used to derive default parameter values.
package huffman_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pack_state_e;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int cnt_width(input int out_w, input int max_len);
    return $clog2(out_w + max_len + 1);
  endfunction

  function automatic int bits_width(input int out_w);
    return $clog2(out_w + 1);
  endfunction

endpackage

// File: rtl/huffman_code_table.sv
// Symbol -> {length, codeword} register file. Lengths clear on reset so every
// symbol reads as absent until loaded; codewords are don't-care until then.
module huffman_code_table
  import huffman_pkg::*;
#(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [SYM_W-1:0]   wr_sym,
  input  logic [LEN_W-1:0]   wr_len,
  input  logic [MAX_LEN-1:0] wr_code,
  input  logic [SYM_W-1:0]   rd_sym,
  output logic [LEN_W-1:0]   rd_len,
  output logic [MAX_LEN-1:0] rd_code
);

  localparam int DEPTH = 1 << SYM_W;

  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] code;
  } tbl_entry_t;

  tbl_entry_t entry_all [DEPTH];
  tbl_entry_t rd_entry;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic               hit;
    logic [LEN_W-1:0]   len_reg;
    logic [MAX_LEN-1:0] code_reg;

    assign hit = wr_en && (wr_sym == SYM_W'(gi));

    always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
        len_reg <= '0;
      end else if (hit) begin
        len_reg <= wr_len;
      end
    end

    // Codewords need no reset: a zero length masks whatever is stored.
    always_ff @(posedge clock) begin
      if (hit) begin
        code_reg <= wr_code;
      end
    end

    assign entry_all[gi] = '{len: len_reg, code: code_reg};
  end

  assign rd_entry = entry_all[rd_sym];
  assign rd_len   = rd_entry.len;
  assign rd_code  = rd_entry.code;

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs Huffman codewords into MSB-first OUT_W-bit words with valid/ready on
// both sides and a final partial-word flush at end of frame.
module huffman_bit_packer
  import huffman_pkg::*;
#(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 16,
  parameter int OUT_W   = 32,
  parameter int LEN_W   = len_width(MAX_LEN),
  parameter int CNT_W   = cnt_width(OUT_W, MAX_LEN)
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       tbl_we,
  input  logic [SYM_W-1:0]           tbl_sym,
  input  logic [LEN_W-1:0]           tbl_len,
  input  logic [MAX_LEN-1:0]         tbl_code,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SYM_W-1:0]           in_sym,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(OUT_W+1)-1:0] out_bits,
  output logic                       out_last,
  output logic                       busy,
  output logic                       err_sym
);

  localparam int ACC_W = OUT_W + MAX_LEN;
  localparam int OB_W  = $clog2(OUT_W + 1);

  pack_state_e        state_reg, state_next;
  logic [CNT_W-1:0]   fill_reg, fill_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic               err_reg;

  logic [LEN_W-1:0]   lk_len;
  logic [MAX_LEN-1:0] lk_code;
  logic               tbl_wr_en;
  logic               accept;
  logic               emit;
  logic [CNT_W-1:0]   emitted;
  logic [CNT_W-1:0]   fill_base;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   code_ext;
  logic [ACC_W-1:0]   code_placed;

  assign tbl_wr_en = tbl_we && (state_reg == IDLE);

  huffman_code_table #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_table (
    .clock   (clock),
    .rst     (rst),
    .wr_en   (tbl_wr_en),
    .wr_sym  (tbl_sym),
    .wr_len  (tbl_len),
    .wr_code (tbl_code),
    .rd_sym  (in_sym),
    .rd_len  (lk_len),
    .rd_code (lk_code)
  );

  // in_ready is a function of registered state only, never of out_ready.
  assign in_ready = rst
                 && ((state_reg == IDLE) || (state_reg == RUN))
                 && (fill_reg < CNT_W'(OUT_W));

  assign out_data = acc_reg[ACC_W-1 -: OUT_W];
  assign busy     = (state_reg != IDLE);
  assign err_sym  = err_reg;

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_bits  = '0;
    case (state_reg)
      RUN: begin
        out_valid = (fill_reg >= CNT_W'(OUT_W));
        out_bits  = OB_W'(OUT_W);
      end
      FLUSH: begin
        out_valid = 1'b1;
        out_last  = (fill_reg <= CNT_W'(OUT_W));
        out_bits  = (fill_reg >= CNT_W'(OUT_W)) ? OB_W'(OUT_W) : OB_W'(fill_reg);
      end
      default: ;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  // Emit first, then place the new code directly below the surviving bits.
  always_comb begin
    emitted     = emit ? CNT_W'(out_bits) : '0;
    fill_base   = fill_reg - emitted;
    acc_base    = emit ? (acc_reg << OUT_W) : acc_reg;
    code_ext    = {{(ACC_W-MAX_LEN){1'b0}}, lk_code};
    code_placed = '0;
    if (accept) begin
      code_placed = (code_ext << (ACC_W - int'(lk_len))) >> fill_base;
    end
    acc_next  = acc_base | code_placed;
    fill_next = fill_base + (accept ? CNT_W'(lk_len) : '0);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = in_last ? FLUSH : RUN;
      RUN:     if (accept && in_last) state_next = FLUSH;
      FLUSH:   if (emit && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      fill_reg  <= '0;
      acc_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      fill_reg  <= fill_next;
      acc_reg   <= acc_next;
      if (accept && (lk_len == '0)) begin
        err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Self-checking bench for huffman_bit_packer (default parameters) against a
// bit-queue reference model of the packed stream.
module tb_huffman_bit_packer;

  logic        clock;
  logic        rst;
  logic        tbl_we;
  logic [7:0]  tbl_sym;
  logic [4:0]  tbl_len;
  logic [15:0] tbl_code;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_sym;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_bits;
  logic        out_last;
  logic        busy;
  logic        err_sym;

  huffman_bit_packer dut (
    .clock     (clock),
    .rst       (rst),
    .tbl_we    (tbl_we),
    .tbl_sym   (tbl_sym),
    .tbl_len   (tbl_len),
    .tbl_code  (tbl_code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bits  (out_bits),
    .out_last  (out_last),
    .busy      (busy),
    .err_sym   (err_sym)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    int          bits;
    bit          last;
  } word_t;

  int          checks = 0;
  int          passed = 0;
  int          failed = 0;
  int          m_len  [256];
  logic [15:0] m_code [256];
  bit          err_m;
  bit          bitq   [$];
  word_t       exp_q  [$];
  logic [7:0]  frame_q[$];
  logic [7:0]  pool   [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int n, input bit last);
    word_t w;
    w.data = '0;
    for (int i = 0; i < n; i++) w.data[31-i] = bitq.pop_front();
    w.bits = n;
    w.last = last;
    exp_q.push_back(w);
  endtask

  // Stream model: code bits appended MSB first; full words leave eagerly
  // mid-frame, and the frame end drains everything with the last flag.
  task automatic model_accept(input logic [7:0] s, input bit last);
    int l;
    bit fin;
    l = m_len[s];
    if (l == 0) err_m = 1'b1;
    for (int b = l - 1; b >= 0; b--) bitq.push_back(m_code[s][b]);
    if (!last) begin
      while (bitq.size() >= 32) push_word(32, 1'b0);
    end else begin
      do begin
        fin = (bitq.size() <= 32);
        push_word(fin ? bitq.size() : 32, fin);
      end while (!fin);
    end
  endtask

  task automatic load(input logic [7:0] s, input int l, input logic [15:0] c);
    @(posedge clock); #1;
    tbl_we = 1'b1; tbl_sym = s; tbl_len = 5'(l); tbl_code = c;
    @(posedge clock); #1;
    tbl_we = 1'b0;
    m_len[s]  = l;
    m_code[s] = c;
  endtask

  task automatic run_frame(input bit rnd, input int stall);
    int    idx;
    int    n;
    int    cyc;
    bit    done;
    bit    hold;
    word_t held;
    word_t w;
    idx = 0; n = frame_q.size(); cyc = 0; done = 1'b0; hold = 1'b0;
    while (!done && cyc < 4000) begin
      @(posedge clock); #1;
      in_valid  = (idx < n) && (!rnd || $urandom_range(0, 3) != 0);
      in_sym    = (idx < n) ? frame_q[idx] : 8'h00;
      in_last   = (idx == n - 1);
      out_ready = (cyc >= stall) && (!rnd || $urandom_range(0, 2) != 0);
      @(negedge clock);
      if (stall > 0 && cyc == stall - 1) begin
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        if (exp_q.size() != 0) check("bp_out_data", out_data, exp_q[0].data);
      end
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held.data);
        check("hold_bits", out_bits, held.bits);
        check("hold_last", out_last, held.last);
      end
      hold = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", out_valid, 0);
        end else begin
          w = exp_q.pop_front();
          $display("word data=%08h bits=%0d last=%0d", out_data, out_bits, out_last);
          check("word_data", out_data, w.data);
          check("word_bits", out_bits, w.bits);
          check("word_last", out_last, w.last);
          if (w.last) done = 1'b1;
        end
      end else if (out_valid) begin
        hold = 1'b1;
        held.data = out_data; held.bits = out_bits; held.last = out_last;
      end
      if (in_valid && in_ready) begin
        model_accept(in_sym, in_last);
        idx++;
      end
      cyc++;
    end
    check("frame_done", done, 1);
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
    @(negedge clock);
    check("end_busy", busy, 0);
    check("end_out_valid", out_valid, 0);
    check("end_in_ready", in_ready, 1);
    check("end_err_sym", err_sym, err_m);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin m_len[i] = 0; m_code[i] = '0; end
    err_m = 1'b0;
    rst = 1'b0; tbl_we = 1'b0; tbl_sym = '0; tbl_len = '0; tbl_code = '0;
    in_valid = 1'b1; in_sym = 8'h41; in_last = 1'b0; out_ready = 1'b0;

    // Reset held with in_valid asserted
    repeat (3) begin
      @(negedge clock);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err_sym", err_sym, 0);
    end
    check("rst_out_data", out_data, 0);
    check("rst_out_bits", out_bits, 0);
    check("rst_out_last", out_last, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clock);
    check("rel_in_ready", in_ready, 1);

    // Partial frame A,B,C,A -> 0101_10 padded
    load(8'h41, 1, 16'h0000);
    load(8'h42, 2, 16'h0002);
    load(8'h43, 2, 16'h0003);
    frame_q = '{8'h41, 8'h42, 8'h43, 8'h41};
    run_frame(1'b0, 0);

    // Exact words: 32 x B = 64 bits
    frame_q.delete();
    for (int i = 0; i < 32; i++) frame_q.push_back(8'h42);
    run_frame(1'b0, 0);

    // Backpressure: sink stalled while streaming B
    frame_q.delete();
    for (int i = 0; i < 20; i++) frame_q.push_back(8'h42);
    run_frame(1'b0, 40);

    // Straddle across the word boundary
    load(8'h10, 16, 16'hFFFF);
    load(8'h11, 8, 16'h0000);
    frame_q = '{8'h11, 8'h11, 8'h11, 8'h10};
    run_frame(1'b0, 0);

    // Randomised table entries and frames
    pool = '{8'h41, 8'h42, 8'h43, 8'h10, 8'h11};
    for (int i = 0; i < 16; i++) begin
      load(8'h80 + 8'(i), (i == 0) ? 16 : $urandom_range(1, 16), 16'($urandom()));
      pool.push_back(8'h80 + 8'(i));
    end
    for (int f = 0; f < 10; f++) begin
      frame_q.delete();
      for (int i = 0; i < $urandom_range(1, 30); i++)
        frame_q.push_back(pool[$urandom_range(0, pool.size() - 1)]);
      run_frame(1'b1, 0);
    end

    // Table write while RUN must be ignored
    @(posedge clock); #1;
    in_valid = 1'b1; in_sym = 8'h42; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    check("wr_run_accept", in_ready, 1);
    model_accept(8'h42, 1'b0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    tbl_we = 1'b1; tbl_sym = 8'h42; tbl_len = 5'd3; tbl_code = 16'h0007;
    @(negedge clock);
    check("wr_run_busy", busy, 1);
    @(posedge clock); #1;
    tbl_we = 1'b0;
    frame_q = '{8'h42};
    run_frame(1'b0, 0);

    // Unknown symbol as an empty frame
    frame_q = '{8'h00};
    run_frame(1'b0, 0);

    // Reset mid-frame
    @(posedge clock); #1;
    in_valid = 1'b1; in_sym = 8'h10; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    check("mid_out_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_bits", out_bits, 0);
    check("mid_rst_err_sym", err_sym, 0);
    @(negedge clock);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) m_len[i] = 0;
    err_m = 1'b0;
    bitq.delete();
    exp_q.delete();
    // Table was cleared: a formerly known symbol is now absent
    frame_q = '{8'h42};
    run_frame(1'b0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
